sseg_mux_dim: RTL and testbench

- Downstream consumer of the four per-digit 8-bit segment patterns produced by the hex/BCD-to-7-seg decoders.
- Time-multiplexes the four digits onto a shared 4-anode / 8-segment display.
- Adds per-digit blanking and 4-bit PWM brightness (dimming) within each digit slot.
- Sits between the decoder instances and the board pins.

---
 rtl/sseg_mux_dim.sv | 90 +++++++++
 tb/tb_sseg_mux_dim.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_mux_dim.sv
// sseg_mux_dim: drives four 8-segment digits over one shared anode/segment bus.
// Each digit gets a slot of 2^(N-2) clocks. Inside the slot, PWM dimming lights
// the digit for the first eff_duty of the 2^DUTY_W sub-slots. Per-digit blanking
// forces a digit dark for its whole slot.
// Optional macro SSEG_MUX_GHOST_GUARD_EN keeps sub-slot 0 of every slot dark.
// This leaves a short dead time at each digit change to reduce ghosting.
// Outputs are registered. Reset is asynchronous and active-low.
module sseg_mux_dim #(
  parameter int N      = 18,
  parameter int DUTY_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in0,
  input  logic [7:0]        in1,
  input  logic [7:0]        in2,
  input  logic [7:0]        in3,
  input  logic [3:0]        blank,
  input  logic [DUTY_W-1:0] duty,
  output logic [3:0]        an,
  output logic [7:0]        seg
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]      r_q;
  logic [DUTY_W-1:0] r_duty;
  logic [3:0]        r_an;
  logic [7:0]        r_seg;

  logic [1:0]        w_sel;
  logic [DUTY_W-1:0] w_phase;
  logic              w_slotStart;
  logic [DUTY_W-1:0] w_effDuty;
  logic [7:0]        w_segIn;
  logic              w_on;

  assign w_sel       = r_q[N-1:N-2];
  assign w_phase     = r_q[N-3 -: DUTY_W];
  assign w_slotStart = (r_q[N-3:0] == '0);
  // At a slot boundary the new duty is used right away. Mid-slot, the latched value applies.
  assign w_effDuty   = w_slotStart ? duty : r_duty;

`ifdef SSEG_MUX_GHOST_GUARD_EN
  assign w_on = (w_phase != '0) && (w_phase < w_effDuty) && !blank[w_sel];
`else
  assign w_on = (w_phase < w_effDuty) && !blank[w_sel];
`endif

  // Select the segment pattern of the digit that owns the current slot.
  always_comb begin
    w_segIn = 8'hFF;
    case (w_sel)
      2'd0:    w_segIn = in0;
      2'd1:    w_segIn = in1;
      2'd2:    w_segIn = in2;
      default: w_segIn = in3;
    endcase
  end

  // Free-running refresh counter. Its top two bits pick the digit, and the bits below pick the PWM phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_q <= '0;
    else          r_q <= r_q + ONE;
  end

  // Capture brightness only at slot start, so a duty change never tears a slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_duty <= '0;
    else if (w_slotStart) r_duty <= duty;
  end

  // Register the anode and segment drive. The bus is fully dark whenever the digit is off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else if (w_on) begin
      r_an  <= ~(4'b0001 << w_sel);
      r_seg <= w_segIn;
    end else begin
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_sseg_mux_dim.sv
// Testbench for sseg_mux_dim with N=8, DUTY_W=4 (64-cycle slots, 4-cycle sub-slots).
// A cycle-count reference model predicts an/seg every clock. Directed checks pin
// literal values and lit-cycle counts. A randomized run then stresses the model comparison.
module tb_sseg_mux_dim;

  localparam int N      = 8;
  localparam int DUTY_W = 4;
  localparam int SLOT   = 64;
  localparam int SUB    = 4;
  localparam int FRAME  = 256;
`ifdef SSEG_MUX_GHOST_GUARD_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in0 = 8'hC0, in1 = 8'hF9, in2 = 8'hA4, in3 = 8'hB0;
  logic [3:0] blank = 4'h0;
  logic [3:0] duty = 4'h0;
  logic [3:0] an;
  logic [7:0] seg;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // Reference model state
  int         cnt = 0;
  int         mDuty = 0;
  int         mSlot, mPhase;
  bit         mOn;
  logic [3:0] expAn = 4'hF;
  logic [7:0] expSeg = 8'hFF;
  logic [7:0] mPat;

  always #5 clk = ~clk;

  sseg_mux_dim #(.N(N), .DUTY_W(DUTY_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .blank(blank), .duty(duty), .an(an), .seg(seg)
  );

  // Reference model: the position in the 256-cycle frame gives the digit and sub-slot.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    = 0;
      mDuty  = 0;
      expAn  = 4'hF;
      expSeg = 8'hFF;
    end else begin
      mSlot  = cnt / SLOT;
      mPhase = (cnt % SLOT) / SUB;
      if (cnt % SLOT == 0) mDuty = int'(duty);
      mOn = (mPhase < mDuty) && (blank[mSlot] == 1'b0) && !(GUARD == 1 && mPhase == 0);
      case (mSlot)
        0: mPat = in0;
        1: mPat = in1;
        2: mPat = in2;
        default: mPat = in3;
      endcase
      expAn  = mOn ? ~(4'b0001 << mSlot) : 4'hF;
      expSeg = mOn ? mPat : 8'hFF;
      cnt    = (cnt + 1) % FRAME;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] gotAn, input logic [3:0] wantAn,
                             input logic [7:0] gotSeg, input logic [7:0] wantSeg);
    vectors++;
    if (gotAn !== wantAn || gotSeg !== wantSeg) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got an=%b seg=%h, want an=%b seg=%h",
               name, $time, gotAn, gotSeg, wantAn, wantSeg);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Compare against the model on every falling edge, and enforce at most one active anode.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model", an, expAn, seg, expSeg);
      vectors++;
      if ($countones(~an) > 1) begin
        miscompares++;
        $display("[TB] FAIL oneHot at %0t: got an=%b, want at most one low bit", $time, an);
      end
    end
  end

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic assertReset();
    reset_n = 1'b0;
    #1;
    checkOutput("resetImmediate", an, 4'hF, seg, 8'hFF);
    advance(3);
    checkOutput("resetHold", an, 4'hF, seg, 8'hFF);
  endtask

  task automatic releaseReset();
    reset_n = 1'b1;
  endtask

  task automatic countLit(input int n, output int lit);
    lit = 0;
    repeat (n) begin
      @(posedge clk);
      #3;
      if (an !== 4'hF) lit++;
    end
  endtask

  task automatic applyStimulus();
    int lit;
    int lit0;
    // 1: basic scan at full brightness
    advance(1);
    checkEn = 1'b1;
    assertReset();
    duty = 4'd15; blank = 4'h0;
    in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
    releaseReset();
    advance(5);   checkOutput("d0Lit",    an, 4'b1110, seg, 8'hC0);
    advance(55);  checkOutput("d0LateLit", an, 4'b1110, seg, 8'hC0);
    advance(1);   checkOutput("d0LastDark", an, 4'b1111, seg, 8'hFF);
    advance(4);   checkOutput("d1Lit",    an, 4'b1101, seg, 8'hF9);
    advance(64);  checkOutput("d2Lit",    an, 4'b1011, seg, 8'hA4);
    advance(64);  checkOutput("d3Lit",    an, 4'b0111, seg, 8'hB0);
    advance(68);  checkOutput("wrapLit",  an, 4'b1110, seg, 8'hC0);

    // 2: duty 0 stays dark
    assertReset();
    duty = 4'd0;
    releaseReset();
    countLit(512, lit);
    checkValue("duty0Dark", lit, 0);

    // 3: half brightness
    assertReset();
    duty = 4'd8;
    releaseReset();
    for (int s = 0; s < 4; s++) begin
      countLit(64, lit);
      checkValue($sformatf("duty8Slot%0d", s), lit, 32 - 4 * GUARD);
    end

    // 4: blank digit 2 only
    assertReset();
    duty = 4'd15; blank = 4'b0100;
    releaseReset();
    for (int s = 0; s < 4; s++) begin
      countLit(64, lit);
      checkValue($sformatf("blankSlot%0d", s), lit, (s == 2) ? 0 : 60 - 4 * GUARD);
    end
    blank = 4'h0;

    // 5: duty change mid-slot applies only at the next slot
    assertReset();
    duty = 4'd15;
    releaseReset();
    lit0 = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #3;
      if (k == 20) duty = 4'd4;
      if (an !== 4'hF) lit0++;
    end
    checkValue("dutyChgSlot0", lit0, 60 - 4 * GUARD);
    countLit(64, lit);
    checkValue("dutyChgSlot1", lit, 16 - 4 * GUARD);

    // 6: async reset in the middle of slot 2
    assertReset();
    duty = 4'd15;
    releaseReset();
    advance(159);
    checkOutput("slot2BeforeReset", an, 4'b1011, seg, 8'hA4);
    assertReset();
    duty = 4'd7;
    releaseReset();
    countLit(64, lit);
    checkValue("restartSlot0", lit, 28 - 4 * GUARD);
    advance(5);
    checkOutput("restartDigit1", an, 4'b1101, seg, in1);

    // Randomized run against the model
    assertReset();
    duty = 4'($urandom); blank = 4'($urandom);
    releaseReset();
    repeat (3000) begin
      @(posedge clk);
      #3;
      in0 = 8'($urandom); in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom);
      if ($urandom_range(7) == 0)  blank = 4'($urandom);
      if ($urandom_range(40) == 0) duty = 4'($urandom);
      if ($urandom_range(999) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
    end
    advance(2);
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
